// File: rtl/sprite_feeder.sv
// Sprite table plus per-frame walker: offers each active sprite to the renderer once
// per video frame and advances per-sprite animation phases every ANIM_DIV frames.
module sprite_feeder #(
  parameter int MAX_SPRITES   = 16,
  parameter int NUM_FRAMES    = 18,
  parameter int CANVAS_WIDTH  = 360,
  parameter int CANVAS_HEIGHT = 720,
  parameter int ANIM_DIV      = 4,
  localparam int IW = $clog2(MAX_SPRITES),
  localparam int FW = $clog2(NUM_FRAMES),
  localparam int XW = $clog2(CANVAS_WIDTH),
  localparam int YW = $clog2(CANVAS_HEIGHT)
) (
  input  logic          clk_pixel,
  input  logic          sys_rst,
  input  logic [5:0]    frame_count,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic          wr_active,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [FW-1:0] wr_base_frame,
  input  logic [1:0]    wr_anim_len,
  input  logic          sprite_ready,
  output logic          sprite_valid,
  output logic [XW-1:0] sprite_x,
  output logic [YW-1:0] sprite_y,
  output logic [FW-1:0] sprite_frame_number,
  output logic          busy,
  output logic          pass_done,
  output logic [7:0]    overrun_count,
  output logic [1:0]    fsm_state
);

  localparam int DW  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FW1 = FW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SCAN    = 2'd1;
  localparam logic [1:0] S_OFFER   = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  logic [5:0]    prev_frame_count;
  logic          new_frame;
  logic [DW-1:0] anim_div;
  logic          anim_tick;

  logic          ent_active [MAX_SPRITES];
  logic [XW-1:0] ent_x      [MAX_SPRITES];
  logic [YW-1:0] ent_y      [MAX_SPRITES];
  logic [FW-1:0] ent_base   [MAX_SPRITES];
  logic [1:0]    ent_len    [MAX_SPRITES];
  logic [1:0]    ent_phase  [MAX_SPRITES];

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [FW1-1:0] cur_frame;
  logic          cur_legal;
  logic          last_idx;

  assign new_frame = (frame_count != prev_frame_count);
  assign anim_tick = new_frame && (anim_div == DW'(ANIM_DIV - 1));

  // Loading the live counter during reset avoids a spurious pass on release.
  always_ff @(posedge clk_pixel) begin
    prev_frame_count <= frame_count;
    if (sys_rst) begin
      anim_div <= '0;
    end else if (new_frame) begin
      anim_div <= anim_tick ? '0 : anim_div + 1'b1;
    end
  end

  // A write always wins over a same-cycle phase advance of that entry.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        ent_active[i] <= 1'b0;
        ent_x[i]      <= '0;
        ent_y[i]      <= '0;
        ent_base[i]   <= '0;
        ent_len[i]    <= '0;
        ent_phase[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        if (wr_en && (wr_addr == IW'(i))) begin
          ent_active[i] <= wr_active;
          ent_x[i]      <= wr_x;
          ent_y[i]      <= wr_y;
          ent_base[i]   <= wr_base_frame;
          ent_len[i]    <= wr_anim_len;
          ent_phase[i]  <= 2'd0;
        end else if (anim_tick && ent_active[i]) begin
          ent_phase[i] <= (ent_phase[i] == ent_len[i]) ? 2'd0 : ent_phase[i] + 2'd1;
        end
      end
    end
  end

  assign cur_frame = {1'b0, ent_base[idx]} + FW1'(ent_phase[idx]);
  assign cur_legal = ent_active[idx] && (cur_frame < FW1'(NUM_FRAMES));
  assign last_idx  = (idx == IW'(MAX_SPRITES - 1));

  // Handshake: an offer is raised with all sprite_* fields registered and held
  // stable until the cycle where sprite_valid && sprite_ready (the transfer);
  // valid only drops early on reset or on a new frame aborting the pass.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      state               <= S_IDLE;
      idx                 <= '0;
      sprite_valid        <= 1'b0;
      sprite_x            <= '0;
      sprite_y            <= '0;
      sprite_frame_number <= '0;
      pass_done           <= 1'b0;
      overrun_count       <= '0;
    end else begin
      pass_done <= 1'b0;
      if (new_frame && (state != S_IDLE)) begin
        state        <= S_SCAN;
        idx          <= '0;
        sprite_valid <= 1'b0;
        if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
      end else begin
        case (state)
          S_IDLE: begin
            if (new_frame) begin
              state <= S_SCAN;
              idx   <= '0;
            end
          end
          S_SCAN: begin
            if (cur_legal) begin
              sprite_x            <= ent_x[idx];
              sprite_y            <= ent_y[idx];
              sprite_frame_number <= cur_frame[FW-1:0];
              sprite_valid        <= 1'b1;
              state               <= S_OFFER;
            end else if (last_idx) begin
              state     <= S_IDLE;
              pass_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_OFFER: begin
            if (sprite_ready) begin
              sprite_valid <= 1'b0;
              state        <= S_HOLDOFF;
            end
          end
          S_HOLDOFF: begin
            // Renderer's registered ready may still read high here; ignore it.
            if (last_idx) begin
              state     <= S_IDLE;
              pass_done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SCAN;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_sprite_feeder.sv
// Bench for sprite_feeder: directed scenarios plus randomized passes checked
// against a frame-count based model of the sprite table.
module tb_sprite_feeder;
  localparam int MAXS = 16;
  localparam int NFR  = 18;
  localparam int ADIV = 4;
  localparam int IW = 4, FW = 5, XW = 9, YW = 10;
  localparam int OW = XW + YW + FW;

  logic          clk_pixel = 1'b0;
  logic          sys_rst = 1'b1;
  logic [5:0]    frame_count = 6'd0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic          wr_active = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic [YW-1:0] wr_y = '0;
  logic [FW-1:0] wr_base_frame = '0;
  logic [1:0]    wr_anim_len = '0;
  logic          sprite_ready = 1'b0;
  logic          sprite_valid;
  logic [XW-1:0] sprite_x;
  logic [YW-1:0] sprite_y;
  logic [FW-1:0] sprite_frame_number;
  logic          busy;
  logic          pass_done;
  logic [7:0]    overrun_count;
  logic [1:0]    fsm_state;

  int checks = 0;
  int fails = 0;

  sprite_feeder dut (
    .clk_pixel(clk_pixel), .sys_rst(sys_rst), .frame_count(frame_count),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_active(wr_active), .wr_x(wr_x), .wr_y(wr_y),
    .wr_base_frame(wr_base_frame), .wr_anim_len(wr_anim_len), .sprite_ready(sprite_ready),
    .sprite_valid(sprite_valid), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_frame_number(sprite_frame_number), .busy(busy), .pass_done(pass_done),
    .overrun_count(overrun_count), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs_q[$];
  int done_cnt = 0;
  int valid_cnt = 0;

  always @(negedge clk_pixel) begin
    if (sprite_valid && sprite_ready) obs_q.push_back({sprite_x, sprite_y, sprite_frame_number});
    if (pass_done) done_cnt++;
    if (sprite_valid) valid_cnt++;
  end

  // ---------------- reference model ----------------
  // Phase = animation ticks elapsed since the entry was written, modulo its length.
  int m_active[MAXS], m_x[MAXS], m_y[MAXS], m_base[MAXS], m_len[MAXS], m_wtick[MAXS];
  int m_events = 0;

  function automatic void model_reset();
    for (int i = 0; i < MAXS; i++) m_active[i] = 0;
    m_events = 0;
  endfunction

  function automatic void model_frame();
    int ph;
    m_events++;
    for (int i = 0; i < MAXS; i++) begin
      if (m_active[i] != 0) begin
        ph = (m_events / ADIV - m_wtick[i]) % (m_len[i] + 1);
        if (m_base[i] + ph < NFR)
          exp_q.push_back({XW'(m_x[i]), YW'(m_y[i]), FW'(m_base[i] + ph)});
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    sys_rst = 1'b1;
    wr_en = 1'b0;
    sprite_ready = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1 sys_rst = 1'b0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic write_entry(input int a, input int act, input int x, input int y,
                             input int b, input int l);
    @(posedge clk_pixel); #1;
    wr_en = 1'b1; wr_addr = IW'(a); wr_active = (act != 0);
    wr_x = XW'(x); wr_y = YW'(y); wr_base_frame = FW'(b); wr_anim_len = 2'(l);
    @(posedge clk_pixel); #1;
    wr_en = 1'b0;
    m_active[a] = act; m_x[a] = x; m_y[a] = y; m_base[a] = b; m_len[a] = l;
    m_wtick[a] = m_events / ADIV;
  endtask

  task automatic frame_event();
    @(posedge clk_pixel); #1;
    frame_count = frame_count + 6'd1;
    model_frame();
  endtask

  task automatic wait_idle(input bit rnd, output int ncyc);
    ncyc = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk_pixel); #1;
      if (rnd) sprite_ready = 1'($urandom_range(0, 1));
      @(negedge clk_pixel);
      if (!busy) break;
      ncyc++;
    end
    #1;
    checks++;
    if (busy) begin fails++; $display("FAIL pass_timeout: busy=%0b after %0d cycles, want 0", busy, ncyc); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    frame_count = 6'd37;
    do_reset();
    @(negedge clk_pixel);
    checks += 8;
    if (sprite_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", sprite_valid); end
    if (sprite_x !== '0) begin fails++; $display("FAIL rst_x got %0d want 0", sprite_x); end
    if (sprite_y !== '0) begin fails++; $display("FAIL rst_y got %0d want 0", sprite_y); end
    if (sprite_frame_number !== '0) begin fails++; $display("FAIL rst_frame got %0d want 0", sprite_frame_number); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b want 0", busy); end
    if (pass_done !== 1'b0) begin fails++; $display("FAIL rst_pass_done got %0b want 0", pass_done); end
    if (overrun_count !== 8'd0) begin fails++; $display("FAIL rst_overrun got %0d want 0", overrun_count); end
    if (fsm_state !== 2'd0) begin fails++; $display("FAIL rst_state got %0d want idle(0)", fsm_state); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_pixel);
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_no_spurious_pass cycle %0d busy=%0b want 0", i, busy); end
    end
  endtask

  task automatic test_empty_pass();
    int n, d0, v0;
    d0 = done_cnt; v0 = valid_cnt;
    frame_event();
    wait_idle(1'b0, n);
    checks += 4;
    if (n !== 16) begin fails++; $display("FAIL empty_busy_cycles got %0d want 16", n); end
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL empty_pass_done got %0d want 1", done_cnt - d0); end
    if (valid_cnt !== v0) begin fails++; $display("FAIL empty_valid got %0d cycles want 0", valid_cnt - v0); end
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL empty_transfers got %0d want %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_two_sprites();
    int n, d0;
    logic [OW-1:0] e0, e1;
    e0 = {9'd100, 10'd200, 5'd5};
    e1 = {9'd0, 10'd656, 5'd17};
    write_entry(2, 1, 100, 200, 5, 0);
    write_entry(7, 1, 0, 656, 17, 0);
    sprite_ready = 1'b1;
    d0 = done_cnt;
    frame_event();
    wait_idle(1'b0, n);
    checks += 3;
    if (n !== 20) begin fails++; $display("FAIL two_busy_cycles got %0d want 20", n); end
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL two_pass_done got %0d want 1", done_cnt - d0); end
    if (obs_q.size() !== 2) begin
      fails++; $display("FAIL two_count got %0d want 2", obs_q.size());
    end else begin
      checks += 2;
      if (obs_q[0] !== e0) begin fails++; $display("FAIL two_first got %h want %h", obs_q[0], e0); end
      if (obs_q[1] !== e1) begin fails++; $display("FAIL two_second got %h want %h", obs_q[1], e1); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL two_model[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_ready_stall();
    int k, n;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [FW-1:0] cf;
    sprite_ready = 1'b0;
    frame_event();
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_pixel);
      if (sprite_valid) begin k = c; break; end
    end
    cx = sprite_x; cy = sprite_y; cf = sprite_frame_number;
    checks += 2;
    if (k !== 5) begin fails++; $display("FAIL stall_first_valid_cycle got %0d want 5", k); end
    if ({cx, cy, cf} !== {9'd100, 10'd200, 5'd5}) begin
      fails++; $display("FAIL stall_offer got (%0d,%0d,%0d) want (100,200,5)", cx, cy, cf);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_pixel);
      checks++;
      if (!(sprite_valid === 1'b1 && sprite_x === cx && sprite_y === cy && sprite_frame_number === cf)) begin
        fails++; $display("FAIL stall_hold cycle %0d got v=%0b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                          i, sprite_valid, sprite_x, sprite_y, sprite_frame_number, cx, cy, cf);
      end
    end
    @(posedge clk_pixel); #1 sprite_ready = 1'b1;
    @(negedge clk_pixel);
    @(negedge clk_pixel); #1;
    checks += 2;
    if (sprite_valid !== 1'b0) begin fails++; $display("FAIL stall_holdoff_valid got %0b want 0", sprite_valid); end
    if (obs_q.size() !== 1) begin fails++; $display("FAIL stall_transfer_count got %0d want 1", obs_q.size()); end
    wait_idle(1'b0, n);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL stall_pass_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_model[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_anim();
    int n;
    int seq[17];
    seq = '{4, 4, 4, 5, 5, 5, 5, 6, 6, 6, 6, 4, 4, 4, 4, 5, 4};
    do_reset();
    write_entry(5, 1, 40, 80, 4, 2);
    sprite_ready = 1'b1;
    for (int e = 0; e < 17; e++) begin
      if (e == 16) write_entry(5, 1, 40, 80, 4, 2);
      frame_event();
      wait_idle(1'b0, n);
      checks++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
        fails++; $display("FAIL anim_count ev %0d got %0d want 1", e + 1, obs_q.size());
      end else begin
        checks += 2;
        if (obs_q[0][FW-1:0] !== FW'(seq[e])) begin
          fails++; $display("FAIL anim_frame ev %0d got %0d want %0d", e + 1, obs_q[0][FW-1:0], seq[e]);
        end
        if (obs_q[0] !== exp_q[0]) begin fails++; $display("FAIL anim_model ev %0d got %h want %h", e + 1, obs_q[0], exp_q[0]); end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_illegal_frame();
    int n;
    int seq[8];
    seq = '{16, 16, 16, 17, 17, 17, 17, -1};
    do_reset();
    write_entry(0, 1, 10, 20, 16, 3);
    write_entry(9, 1, 300, 700, 2, 0);
    sprite_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      frame_event();
      wait_idle(1'b0, n);
      checks++;
      if (obs_q.size() !== ((seq[e] < 0) ? 1 : 2)) begin
        fails++; $display("FAIL illegal_count ev %0d got %0d want %0d", e + 1, obs_q.size(), (seq[e] < 0) ? 1 : 2);
      end else begin
        checks++;
        if (seq[e] >= 0 && obs_q[0][FW-1:0] !== FW'(seq[e])) begin
          fails++; $display("FAIL illegal_frame ev %0d got %0d want %0d", e + 1, obs_q[0][FW-1:0], seq[e]);
        end else if (seq[e] < 0 && obs_q[0] !== {9'd300, 10'd700, 5'd2}) begin
          fails++; $display("FAIL illegal_skip ev %0d got %h want entry 9", e + 1, obs_q[0]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL illegal_model ev %0d [%0d] got %h want %h", e + 1, i, obs_q[i], exp_q[i]); end
        end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int i = 0; i < MAXS; i++)
      write_entry(i, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 359),
                  $urandom_range(0, 719), $urandom_range(0, 17), $urandom_range(0, 3));
    for (int f = 0; f < 14; f++) begin
      if (f % 3 == 2)
        write_entry($urandom_range(0, 15), 1, $urandom_range(0, 359), $urandom_range(0, 719),
                    $urandom_range(0, 17), $urandom_range(0, 3));
      sprite_ready = 1'($urandom_range(0, 1));
      frame_event();
      wait_idle(1'b1, n);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        fails++; $display("FAIL rand_count frame %0d got %0d want %0d", f, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_model frame %0d [%0d] got %h want %h", f, i, obs_q[i], exp_q[i]); end
        end
      end
      obs_q.delete(); exp_q.delete();
    end
    checks++;
    if (overrun_count !== 8'd0) begin fails++; $display("FAIL rand_overrun got %0d want 0", overrun_count); end
  endtask

  task automatic test_abort();
    int n, d0, k;
    do_reset();
    write_entry(2, 1, 100, 200, 5, 0);
    write_entry(7, 1, 0, 656, 17, 0);
    sprite_ready = 1'b0;
    d0 = done_cnt;
    frame_event();
    k = 0;
    for (int c = 1; c <= 40; c++) begin @(negedge clk_pixel); if (sprite_valid) begin k = c; break; end end
    @(posedge clk_pixel); #1 sprite_ready = 1'b1;
    @(posedge clk_pixel); #1 sprite_ready = 1'b0;
    k = 0;
    for (int c = 1; c <= 40; c++) begin @(negedge clk_pixel); if (sprite_valid) begin k = c; break; end end
    checks++;
    if (k == 0 || sprite_x !== 9'd0 || sprite_y !== 10'd656) begin
      fails++; $display("FAIL abort_second_offer got v=%0b (%0d,%0d) want v=1 (0,656)", sprite_valid, sprite_x, sprite_y);
    end
    repeat (3) @(negedge clk_pixel);
    frame_event();
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    checks += 2;
    if (sprite_valid !== 1'b0) begin fails++; $display("FAIL abort_valid_drop got %0b want 0", sprite_valid); end
    if (overrun_count !== 8'd1) begin fails++; $display("FAIL abort_overrun got %0d want 1", overrun_count); end
    k = 0;
    for (int c = 1; c <= 40; c++) begin @(negedge clk_pixel); if (sprite_valid) begin k = c; break; end end
    #1;
    checks += 3;
    if (k == 0 || sprite_x !== 9'd100 || sprite_y !== 10'd200) begin
      fails++; $display("FAIL abort_restart_idx0 got v=%0b (%0d,%0d) want v=1 (100,200)", sprite_valid, sprite_x, sprite_y);
    end
    if (obs_q.size() !== 1) begin fails++; $display("FAIL abort_transfers got %0d want 1", obs_q.size()); end
    if (done_cnt !== d0) begin fails++; $display("FAIL abort_no_pass_done got %0d want %0d", done_cnt, d0); end
    for (int i = 0; i < 300; i++) frame_event();
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    checks += 2;
    if (overrun_count !== 8'd255) begin fails++; $display("FAIL abort_saturate got %0d want 255", overrun_count); end
    if (done_cnt !== d0) begin fails++; $display("FAIL abort_storm_pass_done got %0d want %0d", done_cnt, d0); end
    sprite_ready = 1'b1;
    wait_idle(1'b0, n);
    checks += 2;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL abort_final_pass_done got %0d want 1", done_cnt - d0); end
    if (overrun_count !== 8'd255) begin fails++; $display("FAIL abort_hold_sat got %0d want 255", overrun_count); end
    obs_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_empty_pass();
    test_two_sprites();
    test_ready_stall();
    test_anim();
    test_illegal_frame();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
